// File: rtl/pp_pipeline_accel_norm_quant.sv
// pp_pipeline_accel_norm_quant: bias, rounded shift and saturate a product stream into framed 8-bit pixels
module pp_pipeline_accel_norm_quant #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int DIM_W = 12
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   cols,
  input  logic [DIM_W-1:0]   rows,
  input  logic signed [15:0] bias,
  input  logic [4:0]         shift,
  output logic               busy,
  output logic               done,
  input  logic [IN_W-1:0]    prod_data,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [OUT_W-1:0]   pix_data,
  output logic               pix_user,
  output logic               pix_last,
  output logic               pix_valid,
  input  logic               pix_ready
);
  localparam int SW = IN_W + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] cols_q, rows_q, in_col_q, in_row_q;
  logic signed [15:0] bias_q;
  logic [4:0] shift_q;
  logic in_done_q, done_q;
  logic s1_valid_q, s1_user_q, s1_last_q;
  logic signed [SW-1:0] s1_sum_q;
  logic s2_valid_q, s2_user_q, s2_last_q;
  logic [OUT_W-1:0] s2_data_q;
  logic adv1, adv2, acc, col_end, row_end, start_ok, drain_exit;
  logic signed [SW-1:0] rnd, q;
  logic [OUT_W-1:0] pix_d;
  assign adv2       = !s2_valid_q || pix_ready;
  assign adv1       = !s1_valid_q || adv2;
  assign prod_ready = (state_q == RUN) && !in_done_q && adv1;
  assign acc        = prod_valid && prod_ready;
  assign col_end    = in_col_q == cols_q - DIM_W'(1);
  assign row_end    = in_row_q == rows_q - DIM_W'(1);
  assign start_ok   = (state_q == IDLE) && start;
  assign drain_exit = (state_q == DRAIN) && !s1_valid_q && adv2;
  assign busy       = state_q != IDLE;
  assign done       = done_q;
  assign pix_valid  = s2_valid_q;
  assign pix_data   = s2_data_q;
  assign pix_user   = s2_user_q;
  assign pix_last   = s2_last_q;
  // Frame sequencing: zero-sized frames skip RUN, DRAIN waits for the last output handshake
  always_comb begin
    state_d = state_q;
    if (start_ok) state_d = (cols == '0 || rows == '0) ? DRAIN : RUN;
    else if (state_q == RUN && acc && col_end && row_end) state_d = DRAIN;
    else if (drain_exit) state_d = IDLE;
  end
  // Round half up, arithmetic shift, then clamp to the unsigned pixel range
  always_comb begin
    rnd   = s1_sum_q + ((shift_q != 5'd0) ? (SW'(1) << (shift_q - 5'd1)) : '0);
    q     = rnd >>> shift_q;
    pix_d = (q < 0) ? '0 : (q > $signed(SW'(2**OUT_W - 1))) ? '1 : q[OUT_W-1:0];
  end
  // FSM state, shadow configuration and input beat counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      cols_q    <= '0;
      rows_q    <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      in_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= drain_exit;
      if (start_ok) begin
        cols_q    <= cols;
        rows_q    <= rows;
        bias_q    <= bias;
        shift_q   <= (shift > 5'd24) ? 5'd24 : shift;
        in_col_q  <= '0;
        in_row_q  <= '0;
        in_done_q <= 1'b0;
      end else if (acc) begin
        in_col_q  <= col_end ? '0 : in_col_q + DIM_W'(1);
        in_row_q  <= !col_end ? in_row_q : row_end ? '0 : in_row_q + DIM_W'(1);
        in_done_q <= col_end && row_end;
      end
    end
  end
  // Two-stage datapath; frame markers are captured at input and travel with each beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_user_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_user_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= acc;
        if (acc) begin
          s1_sum_q  <= $signed({2'b00, prod_data}) + $signed({{(SW-16){bias_q[15]}}, bias_q});
          s1_user_q <= (in_col_q == '0) && (in_row_q == '0);
          s1_last_q <= col_end;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= pix_d;
          s2_user_q <= s1_user_q;
          s2_last_q <= s1_last_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_pp_pipeline_accel_norm_quant.sv
// tb_pp_pipeline_accel_norm_quant: scoreboard bench for the norm/quant stage
module tb_pp_pipeline_accel_norm_quant;
  logic ap_clk = 0, ap_rst_n = 0, start = 0, prod_valid = 0, pix_ready = 1;
  logic [11:0] cols = 0, rows = 0;
  logic signed [15:0] bias = 0;
  logic [4:0] shift = 0;
  logic [31:0] prod_data = 0;
  logic busy, done, prod_ready, pix_user, pix_last, pix_valid;
  logic [7:0] pix_data;
  int total = 0, bad = 0, cyc = 0, outs = 0, last_hs = 0, first_out = -1, first_acc = -1;
  int fc, fr, bc, br, st_cyc, d, outs0;
  bit ignore_out = 0, rand_ready = 0, stall_v = 0;
  logic [9:0] stall_val, e;
  logic [9:0] exp_q[$];

  pp_pipeline_accel_norm_quant dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .cols(cols), .rows(rows),
    .bias(bias), .shift(shift), .busy(busy), .done(done), .prod_data(prod_data),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .pix_data(pix_data),
    .pix_user(pix_user), .pix_last(pix_last), .pix_valid(pix_valid), .pix_ready(pix_ready));

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(posedge ap_clk) if (rand_ready) #1 pix_ready = 1'($urandom_range(0, 1));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(longint p, longint b, int s);
    longint v;
    int sc;
    sc = (s > 24) ? 24 : s;
    v = p + b;
    if (sc > 0) v += longint'(1) << (sc - 1);
    if (v < 0) return 8'd0;
    v = v / (longint'(1) << sc);
    return (v > 255) ? 8'd255 : v[7:0];
  endfunction

  always @(negedge ap_clk) begin
    if (!ap_rst_n) stall_v = 0;
    else begin
      if (stall_v) check("stall_hold", {21'd0, pix_valid, pix_data, pix_user, pix_last}, {21'd0, 1'b1, stall_val});
      if (pix_valid && pix_ready && !ignore_out) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h want none", pix_data);
        end else begin
          e = exp_q.pop_front();
          check("pix", {pix_data, pix_user, pix_last}, e);
        end
        outs++;
        last_hs = cyc;
        if (first_out < 0) first_out = cyc;
      end
      stall_v = pix_valid && !pix_ready;
      stall_val = {pix_data, pix_user, pix_last};
    end
  end

  task automatic start_frame(int c, int r, int b, int s);
    @(posedge ap_clk); #1;
    start = 1; cols = 12'(c); rows = 12'(r); bias = 16'(b); shift = 5'(s);
    fc = c; fr = r; bc = 0; br = 0; st_cyc = cyc;
    @(posedge ap_clk); #1;
    start = 0; cols = 12'd7; rows = 12'd9; bias = 16'sd1234; shift = 5'd2;
  endtask

  task automatic send(logic [31:0] p, logic [7:0] ex);
    bit acc;
    int n;
    if (!ignore_out) exp_q.push_back({ex, bc == 0 && br == 0, bc == fc - 1});
    if (bc == fc - 1) begin bc = 0; br++; end else bc++;
    prod_valid = 1; prod_data = p; acc = 0; n = 0;
    while (!acc && n < 200) begin
      @(negedge ap_clk);
      acc = prod_ready;
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge ap_clk); #1;
      n++;
    end
    if (!acc) begin total++; bad++; $display("FAIL accept_timeout: got none want accept"); end
    prod_valid = 0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 300 && dc < 0; i++) begin
      @(negedge ap_clk);
      if (done) begin dc = cyc; check("busy_at_done", busy, 0); end
    end
    if (dc < 0) begin total++; bad++; $display("FAIL done_timeout: got none want done"); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge ap_clk);
    check("reset_outs", {prod_ready, pix_valid, pix_data, pix_user, pix_last, busy, done}, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    start_frame(2, 1, 0, 8);
    send(32'h7F80, 8'd128);
    send(32'h10000, 8'd255);
    wait_done(d);
    start_frame(1, 1, -200, 0);
    send(32'd100, 8'd0);
    wait_done(d);
    start_frame(1, 1, 5, 0);
    send(32'd250, 8'd255);
    wait_done(d);
    start_frame(4, 1, 0, 4);
    send(32'd24, 8'd2);
    send(32'd23, 8'd1);
    send(32'd8, 8'd1);
    send(32'd7, 8'd0);
    wait_done(d);
    start_frame(1, 1, 0, 31);
    send(32'h7F80_0000, 8'd128);
    wait_done(d);
    first_acc = -1; first_out = -1;
    start_frame(3, 2, 0, 8);
    for (int k = 1; k <= 6; k++) send(32'(k << 8), 8'(k));
    @(negedge ap_clk);
    check("ready_after_last", prod_ready, 0);
    wait_done(d);
    check("latency", first_out - first_acc, 2);
    check("done_timing", d - last_hs, 1);
    @(negedge ap_clk);
    check("done_pulse", done, 0);
    outs0 = outs;
    rand_ready = 1;
    start_frame(16, 4, -300, 6);
    for (int i = 0; i < 64; i++) begin
      logic [31:0] p;
      repeat ($urandom_range(0, 1)) begin @(posedge ap_clk); #1; end
      p = $urandom_range(0, 40000);
      send(p, model(p, -300, 6));
    end
    wait_done(d);
    rand_ready = 0;
    @(posedge ap_clk); #2 pix_ready = 1;
    check("bp_count", outs - outs0, 64);
    check("bp_queue_empty", exp_q.size(), 0);
    outs0 = outs;
    start_frame(4, 0, 0, 0);
    wait_done(d);
    check("zero_done", d - st_cyc, 2);
    check("zero_outs", outs - outs0, 0);
    ignore_out = 1;
    start_frame(4, 4, 0, 0);
    for (int i = 0; i < 3; i++) send(32'd50, 8'd50);
    #2 ap_rst_n = 0;
    #1 check("rst_midframe", {prod_ready, pix_valid, pix_data, pix_user, pix_last, busy, done}, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1; ignore_out = 0;
    repeat (4) begin
      @(negedge ap_clk);
      check("idle_after_rst", {done, busy, pix_valid}, 0);
    end
    start_frame(2, 2, 0, 0);
    send(32'd10, 8'd10);
    send(32'd300, 8'd255);
    send(32'd0, 8'd0);
    send(32'd77, 8'd77);
    wait_done(d);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
